// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : CP0 register numbers, exception codes, bit positions and FSM
//               state type shared by the exception controller and its timer.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        ENTER = 1'b1
    } cp0_state_t;

    // Fixed-priority encoder; interrupts outrank every synchronous cause.
    function automatic logic [4:0] exc_code(input logic int_req, input logic [6:0] vec);
        logic [4:0] code;
        code = EXC_INT;
        if (int_req)     code = EXC_INT;
        else if (vec[0]) code = EXC_ADEL;
        else if (vec[1]) code = EXC_RI;
        else if (vec[2]) code = EXC_OV;
        else if (vec[3]) code = EXC_SYS;
        else if (vec[4]) code = EXC_BP;
        else if (vec[5]) code = EXC_ADEL;
        else if (vec[6]) code = EXC_ADES;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer; Count advances every second clock and a
//               match raises a sticky TI that only a Compare write clears.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic        ti,
    output logic [31:0] count,
    output logic [31:0] compare
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_toggle;
    logic        r_ti;
    logic [31:0] w_count_inc;

    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_toggle  <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            if (count_we) begin
                r_count  <= wdata;
                r_toggle <= 1'b0;
            end else begin
                r_toggle <= ~r_toggle;
                if (r_toggle) r_count <= w_count_inc;
            end
            // The match is taken as Count steps onto Compare, so a freshly
            // reset timer (both zero) does not fire until Count wraps.
            if (compare_we) begin
                r_compare <= wdata;
                r_ti      <= 1'b0;
            end else if (!count_we && r_toggle && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign ti      = r_ti;
    assign count   = r_count;
    assign compare = r_compare;

endmodule
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_ctrl
// Description : CP0 exception controller: Status/Cause/EPC/BadVAddr, priority
//               encoding, ERET/MTC0 arbitration and flush/redirect FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [6:0]  exc_vec,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic [31:0] epc_out
);

    cp0_state_t  r_state;
    logic        r_flush;
    logic [31:0] r_redirect_pc;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;
    logic [5:0]  r_ip_hw;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [7:0]  w_ip;
    logic        w_int_req;
    logic        w_run;
    logic        w_take;
    logic        w_eret;
    logic        w_mtc0;
    logic [4:0]  w_code;
    logic        w_addr_exc;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    assign w_ip       = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
    assign w_int_req  = r_ie & ~r_exl & (|(w_ip & r_im));
    assign w_run      = (r_state == RUN);
    assign w_take     = w_run & exc_valid & (w_int_req | (|exc_vec));
    assign w_eret     = w_run & exc_valid & eret & ~w_take;
    assign w_mtc0     = w_run & cp0_we & ~w_take & ~w_eret;
    assign w_code     = exc_code(w_int_req, exc_vec);
    assign w_addr_exc = (w_code == EXC_ADEL) || (w_code == EXC_ADES);

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (w_mtc0 && (cp0_addr == REG_COUNT)),
        .compare_we (w_mtc0 && (cp0_addr == REG_COMPARE)),
        .wdata      (cp0_wdata),
        .ti         (w_ti),
        .count      (w_count),
        .compare    (w_compare)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exccode  <= 5'd0;
            r_ip_sw    <= 2'd0;
            r_ip_hw    <= 6'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            r_ip_hw <= hw_int;
            if (w_take) begin
                r_exccode <= w_code;
                r_exl     <= 1'b1;
                // Nested exceptions keep the original return point.
                if (!r_exl) begin
                    r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                    r_bd  <= exc_bd;
                end
                if (w_addr_exc) r_badvaddr <= exc_badvaddr;
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end else if (w_mtc0) begin
                case (cp0_addr)
                    REG_STATUS: begin
                        r_im  <= cp0_wdata[STATUS_IM_LSB +: 8];
                        r_exl <= cp0_wdata[STATUS_EXL];
                        r_ie  <= cp0_wdata[STATUS_IE];
                    end
                    REG_CAUSE: r_ip_sw <= cp0_wdata[CAUSE_IP_LSB +: 2];
                    REG_EPC:   r_epc   <= cp0_wdata;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_flush       <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_take) begin
                        r_state       <= ENTER;
                        r_flush       <= 1'b1;
                        r_redirect_pc <= EXC_VECTOR;
                    end else if (w_eret) begin
                        r_state       <= ENTER;
                        r_flush       <= 1'b1;
                        r_redirect_pc <= r_epc;
                    end
                end
                ENTER: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_status = 32'd0;
        w_status[STATUS_BEV]        = 1'b1;
        w_status[STATUS_IM_LSB +: 8] = r_im;
        w_status[STATUS_EXL]        = r_exl;
        w_status[STATUS_IE]         = r_ie;
    end

    always_comb begin
        w_cause = 32'd0;
        w_cause[CAUSE_BD]            = r_bd;
        w_cause[CAUSE_TI]            = w_ti;
        w_cause[CAUSE_IP_LSB +: 8]   = w_ip;
        w_cause[CAUSE_EXC_LSB +: 5]  = r_exccode;
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            REG_BADVADDR: cp0_rdata = r_badvaddr;
            REG_COUNT:    cp0_rdata = w_count;
            REG_COMPARE:  cp0_rdata = w_compare;
            REG_STATUS:   cp0_rdata = w_status;
            REG_CAUSE:    cp0_rdata = w_cause;
            REG_EPC:      cp0_rdata = r_epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign status_out  = w_status;
    assign cause_out   = w_cause;
    assign epc_out     = r_epc;

endmodule
`default_nettype wire

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception controller for the five-stage MIPS core. It sequences all CP0 state (Status, Cause, EPC, BadVAddr, Count, Compare) on exception entry, ERET, MTC0/MFC0 and timer/hardware interrupts. It sits beside the MEM/WB commit point and drives the pipeline flush and PC redirect.

## Interface
- No parameters; constants live in `cp0_pkg`.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low; clears all state.
- `exc_valid` in 1: committing instruction is valid this cycle.
- `exc_vec` in 7: flags [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-load, [6] AdES.
- `exc_pc` in 32: PC of the committing instruction.
- `exc_bd` in 1: the committing instruction is in a delay slot.
- `exc_badvaddr` in 32: faulting address (fetch PC or load/store address).
- `eret` in 1: committing instruction is ERET.
- `hw_int` in 6: external interrupt lines, level-sensitive, mapped to IP[7:2].
- `cp0_we` in 1: MTC0 commit.
- `cp0_addr` in 5: CP0 register number.
- `cp0_wdata` in 32: MTC0 data.
- `cp0_rdata` out 32: MFC0 data, combinational from `cp0_addr`.
- `flush` out 1: one-cycle pipeline flush.
- `redirect_pc` out 32: fetch target, valid while `flush`=1.
- `status_out`, `cause_out`, `epc_out` out 32 each: live register copies.

## Operation
- Registers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Reads of any other address return 0.
- Status writable bits: IM[15:8], EXL[1], IE[0]. BEV[22] is hardwired to 1. All other bits read 0.
- Cause layout: BD[31], TI[30], IP[15:8], ExcCode[6:2]. Only IP[9:8] is software-writable.
  - IP[15:10] tracks `hw_int` every cycle.
  - IP[15] is ORed with TI.
- Interrupt pending: `int_req = IE & ~EXL & |(IP & IM)`.
- An exception is taken only when `exc_valid`=1 and (`int_req` or `|exc_vec`).
- Priority: Int(0x00) > AdEL-fetch(0x04) > RI(0x0A) > Ov(0x0C) > Sys(0x08) > Bp(0x09) > AdEL-load(0x04) > AdES(0x05).
- On an exception:
  - Write ExcCode and set EXL.
  - If EXL was 0: EPC = `exc_bd` ? `exc_pc`-4 : `exc_pc`, and BD = `exc_bd`.
  - If EXL was already 1: EPC and BD are held.
  - BadVAddr is written only for the AdEL/AdES codes.
  - Redirect target is 0xBFC00380.
- ERET (`exc_valid`=1 and no exception taken): clear EXL; redirect target is EPC.
- FSM states:
  - RUN → ENTER on exception, or RUN → ENTER on ERET.
  - ENTER asserts `flush` and returns to RUN unconditionally.
  - In ENTER, all commit inputs (`exc_valid`, `eret`, `cp0_we`) are ignored.
- Simultaneous events:
  - Exception beats ERET and MTC0; the MTC0 is discarded.
  - ERET beats MTC0.
  - A timer match in the same cycle as an MTC0 to Compare: the write wins and TI clears.
- Timer:
  - Count increments on every second `clk`, using an internal toggle.
  - Count == Compare sets TI, sticky until Compare is written.
  - An MTC0 to Count loads the value and resets the toggle.
- Arithmetic: 32-bit unsigned. Count wraps 0xFFFFFFFF → 0. EPC-4 wraps modulo 2^32.

## Timing
- Reset values:
  - Status = 0x00400000; Cause, EPC, BadVAddr, Count, Compare = 0.
  - Toggle = 0; FSM = RUN; `flush` = 0; `redirect_pc` = 0.
- If the event commits at cycle N: CP0 registers update at the edge ending N, and `flush`/`redirect_pc` are registered high during N+1 only.
- An MTC0 is visible on `cp0_rdata` and the `*_out` ports from N+1.
- An MFC0 in the same cycle as an MTC0 to the same register returns the old value.
- The interrupt decision uses register values at cycle N, so an MTC0 setting IE at N can raise an interrupt at N+1 at the earliest.
- Reset asserted mid-ENTER: `flush` drops immediately (asynchronous), and the FSM returns to RUN.

## Structure
- `cp0_pkg`:
  - CP0 register-number constants.
  - ExcCode constants.
  - Status/Cause bit-position constants.
  - EXC_VECTOR = 32'hBFC00380.
  - FSM state enum {RUN, ENTER}.
- Sub-module `cp0_timer`:
  - Contains Count, Compare, the toggle and TI.
  - Ports: write strobes, write data, TI, Count/Compare outputs.
- Top level holds Status, Cause, EPC, BadVAddr, the priority encoder and the FSM.

## Test plan
- Reset, then MFC0 of Status → 0x00400000; all other registers → 0; `flush`=0.
- Ov in a delay slot with `exc_pc`=0x80001004, EXL=0:
  - Next cycle `flush`=1 and `redirect_pc`=0xBFC00380.
  - EPC=0x80001000, BD=1, ExcCode=0x0C, EXL=1.
- AdES with `exc_badvaddr`=0x00000003 while EXL=1:
  - ExcCode=0x05 and BadVAddr=0x00000003.
  - EPC and BD are unchanged.
- ERET with EPC=0x80002000 plus `cp0_we` in the same cycle:
  - `flush`=1, `redirect_pc`=0x80002000, EXL=0.
  - The MTC0 is discarded.
- MTC0 Compare=5, Count=0 with IM[7]=1, IE=1:
  - TI sets after 10 cycles.
  - The next `exc_valid` takes Int (ExcCode 0x00).
  - MTC0 to Compare clears TI.
- Sys and RI asserted together → ExcCode 0x0A. A second exception during ENTER is ignored.
